// File: rtl/layer_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_cfg_sequencer
// Description : Holds a software-written table of per-layer convolution
//               configurations. Each entry has image dims, kernel, channels,
//               mode and SRAM bases. On run_start the block walks layers
//               0..run_last. For each layer it validates the entry against
//               the synthesized hardware limits, derives the output
//               dimensions and presents that one layer to the conv datapath
//               with a valid/ready handshake. It steps to the next layer
//               when the datapath signals layer_done.
// Ports       :
//   clk, rst                  clock, asynchronous active-high reset
//   cfg_wr_en/addr/wr_data    host table write; addr = {layer, field}
//   cfg_wr_err                1-cycle pulse, write rejected
//   run_start, run_last       start a run over layers 0..run_last
//   layer_valid/ready         active-layer handshake to the datapath
//   layer_done                datapath finished the active layer
//   act_*                     active layer config and derived OUT_W/OUT_H
//   busy, run_done            sequencer not idle / run-complete pulse
//   err, err_code             sticky validation error and its cause
//   cfg_rd_en, cfg_rd_data    table readback (only with CFG_READBACK_EN)
// Options     : define CFG_READBACK_EN to add the table readback port
// Revision    : 1.0 - initial release
// ============================================================================
module layer_cfg_sequencer #(
    parameter int NUM_LAYERS  = 4,
    parameter int DIM_W       = 11,
    parameter int MAX_K_R     = 7,
    parameter int MAX_LINE_W  = 1920,
    parameter int MAX_CH      = 16,
    parameter int SRAM_ADDR_W = 12,
    parameter int LIDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_wr_en,
    input  logic [LIDX_W+2:0]      cfg_addr,
    input  logic [31:0]            cfg_wr_data,
    output logic                   cfg_wr_err,
    input  logic                   run_start,
    input  logic [LIDX_W-1:0]      run_last,
    output logic                   layer_valid,
    input  logic                   layer_ready,
    input  logic                   layer_done,
    output logic [LIDX_W-1:0]      act_layer,
    output logic [DIM_W-1:0]       act_img_w,
    output logic [DIM_W-1:0]       act_img_h,
    output logic [2:0]             act_k_r,
    output logic [2:0]             act_k_s,
    output logic [4:0]             act_k_ch,
    output logic                   act_mode,
    output logic [DIM_W-1:0]       act_out_w,
    output logic [DIM_W-1:0]       act_out_h,
    output logic [SRAM_ADDR_W-1:0] act_ifm,
    output logic [SRAM_ADDR_W-1:0] act_ofm,
    output logic                   busy,
    output logic                   run_done,
    output logic                   err,
    output logic [2:0]             err_code
`ifdef CFG_READBACK_EN
    ,
    input  logic                   cfg_rd_en,
    output logic [31:0]            cfg_rd_data
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_BUSY  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [2:0] F_IMG_W    = 3'd0;
    localparam logic [2:0] F_IMG_H    = 3'd1;
    localparam logic [2:0] F_K_R      = 3'd2;
    localparam logic [2:0] F_K_S      = 3'd3;
    localparam logic [2:0] F_K_CH     = 3'd4;
    localparam logic [2:0] F_MODE     = 3'd5;
    localparam logic [2:0] F_IFM_BASE = 3'd6;
    localparam logic [2:0] F_OFM_BASE = 3'd7;

    // ------------------------------------------------------------------
    // Configuration table
    // ------------------------------------------------------------------
    logic [DIM_W-1:0]       tab_img_w_q [NUM_LAYERS];
    logic [DIM_W-1:0]       tab_img_w_d [NUM_LAYERS];
    logic [DIM_W-1:0]       tab_img_h_q [NUM_LAYERS];
    logic [DIM_W-1:0]       tab_img_h_d [NUM_LAYERS];
    logic [2:0]             tab_k_r_q   [NUM_LAYERS];
    logic [2:0]             tab_k_r_d   [NUM_LAYERS];
    logic [2:0]             tab_k_s_q   [NUM_LAYERS];
    logic [2:0]             tab_k_s_d   [NUM_LAYERS];
    logic [4:0]             tab_k_ch_q  [NUM_LAYERS];
    logic [4:0]             tab_k_ch_d  [NUM_LAYERS];
    logic                   tab_mode_q  [NUM_LAYERS];
    logic                   tab_mode_d  [NUM_LAYERS];
    logic [SRAM_ADDR_W-1:0] tab_ifm_q   [NUM_LAYERS];
    logic [SRAM_ADDR_W-1:0] tab_ifm_d   [NUM_LAYERS];
    logic [SRAM_ADDR_W-1:0] tab_ofm_q   [NUM_LAYERS];
    logic [SRAM_ADDR_W-1:0] tab_ofm_d   [NUM_LAYERS];

    // ------------------------------------------------------------------
    // Sequencer and active-layer state
    // ------------------------------------------------------------------
    logic [2:0]             state_q,      state_d;
    logic [LIDX_W-1:0]      idx_q,        idx_d;
    logic [LIDX_W-1:0]      last_q,       last_d;
    logic                   err_q,        err_d;
    logic [2:0]             err_code_q,   err_code_d;
    logic                   cfg_wr_err_q, cfg_wr_err_d;
    logic [LIDX_W-1:0]      act_layer_q,  act_layer_d;
    logic [DIM_W-1:0]       act_img_w_q,  act_img_w_d;
    logic [DIM_W-1:0]       act_img_h_q,  act_img_h_d;
    logic [2:0]             act_k_r_q,    act_k_r_d;
    logic [2:0]             act_k_s_q,    act_k_s_d;
    logic [4:0]             act_k_ch_q,   act_k_ch_d;
    logic                   act_mode_q,   act_mode_d;
    logic [DIM_W-1:0]       act_out_w_q,  act_out_w_d;
    logic [DIM_W-1:0]       act_out_h_q,  act_out_h_d;
    logic [SRAM_ADDR_W-1:0] act_ifm_q,    act_ifm_d;
    logic [SRAM_ADDR_W-1:0] act_ofm_q,    act_ofm_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [LIDX_W-1:0]      w_addr_layer;
    logic [2:0]             w_addr_field;
    logic                   w_layer_ok;
    logic                   w_over;
    logic                   w_wr_accept;
    logic [LIDX_W-1:0]      w_run_last;
    logic [DIM_W-1:0]       w_cur_img_w;
    logic [DIM_W-1:0]       w_cur_img_h;
    logic [2:0]             w_cur_k_r;
    logic [2:0]             w_cur_k_s;
    logic [4:0]             w_cur_k_ch;
    logic                   w_k_big;
    logic                   w_w_big;
    logic                   w_ch_big;
    logic                   w_k_bad;
    logic                   w_fit_bad;
    logic                   w_ch_bad;
    logic [2:0]             w_code;

    assign w_addr_layer = cfg_addr[LIDX_W+2:3];
    assign w_addr_field = cfg_addr[2:0];

    // When the table size is a power of two every layer address is valid and
    // every run_last value is in range, so the range checks vanish.
    generate
        if ((1 << LIDX_W) == NUM_LAYERS) begin : g_lidx_full
            assign w_layer_ok = 1'b1;
            assign w_run_last = run_last;
        end else begin : g_lidx_partial
            assign w_layer_ok = (w_addr_layer < LIDX_W'(NUM_LAYERS));
            assign w_run_last = (run_last < LIDX_W'(NUM_LAYERS)) ? run_last
                                                                 : LIDX_W'(NUM_LAYERS - 1);
        end
    endgenerate

    // A value with any bit set above its field width is rejected outright
    // instead of being silently truncated into the table.
    always_comb begin
        w_over = 1'b0;
        case (w_addr_field)
            F_IMG_W, F_IMG_H:       w_over = |(cfg_wr_data >> DIM_W);
            F_K_R, F_K_S:           w_over = |(cfg_wr_data >> 3);
            F_K_CH:                 w_over = |(cfg_wr_data >> 5);
            F_MODE:                 w_over = |(cfg_wr_data >> 1);
            F_IFM_BASE, F_OFM_BASE: w_over = |(cfg_wr_data >> SRAM_ADDR_W);
            default:                w_over = 1'b0;
        endcase
    end

    assign w_wr_accept  = cfg_wr_en && (state_q == S_IDLE) && !w_over && w_layer_ok;
    assign cfg_wr_err_d = cfg_wr_en && ((state_q != S_IDLE) || w_over);

    always_comb begin
        tab_img_w_d = tab_img_w_q;
        tab_img_h_d = tab_img_h_q;
        tab_k_r_d   = tab_k_r_q;
        tab_k_s_d   = tab_k_s_q;
        tab_k_ch_d  = tab_k_ch_q;
        tab_mode_d  = tab_mode_q;
        tab_ifm_d   = tab_ifm_q;
        tab_ofm_d   = tab_ofm_q;
        if (w_wr_accept) begin
            case (w_addr_field)
                F_IMG_W:    tab_img_w_d[w_addr_layer] = cfg_wr_data[DIM_W-1:0];
                F_IMG_H:    tab_img_h_d[w_addr_layer] = cfg_wr_data[DIM_W-1:0];
                F_K_R:      tab_k_r_d[w_addr_layer]   = cfg_wr_data[2:0];
                F_K_S:      tab_k_s_d[w_addr_layer]   = cfg_wr_data[2:0];
                F_K_CH:     tab_k_ch_d[w_addr_layer]  = cfg_wr_data[4:0];
                F_MODE:     tab_mode_d[w_addr_layer]  = cfg_wr_data[0];
                F_IFM_BASE: tab_ifm_d[w_addr_layer]   = cfg_wr_data[SRAM_ADDR_W-1:0];
                default:    tab_ofm_d[w_addr_layer]   = cfg_wr_data[SRAM_ADDR_W-1:0];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Validation of the entry addressed by idx_q (idx_q is always in range)
    // ------------------------------------------------------------------
    assign w_cur_img_w = tab_img_w_q[idx_q];
    assign w_cur_img_h = tab_img_h_q[idx_q];
    assign w_cur_k_r   = tab_k_r_q[idx_q];
    assign w_cur_k_s   = tab_k_s_q[idx_q];
    assign w_cur_k_ch  = tab_k_ch_q[idx_q];

    // Limits that a field's width can never exceed need no comparator.
    generate
        if (MAX_K_R >= 7) begin : g_k_unbounded
            assign w_k_big = 1'b0;
        end else begin : g_k_bounded
            assign w_k_big = (w_cur_k_r > 3'(MAX_K_R)) || (w_cur_k_s > 3'(MAX_K_R));
        end
        if (MAX_LINE_W >= (1 << DIM_W) - 1) begin : g_w_unbounded
            assign w_w_big = 1'b0;
        end else begin : g_w_bounded
            assign w_w_big = (w_cur_img_w > DIM_W'(MAX_LINE_W));
        end
        if (MAX_CH >= 31) begin : g_ch_unbounded
            assign w_ch_big = 1'b0;
        end else begin : g_ch_bounded
            assign w_ch_big = (w_cur_k_ch > 5'(MAX_CH));
        end
    endgenerate

    assign w_k_bad   = (w_cur_k_r == 3'd0) || (w_cur_k_s == 3'd0) || w_k_big;
    assign w_fit_bad = (DIM_W'(w_cur_k_s) > w_cur_img_w) || (DIM_W'(w_cur_k_r) > w_cur_img_h);
    assign w_ch_bad  = (w_cur_k_ch == 5'd0) || w_ch_big;

    // Priority order: the lowest-numbered failing rule is reported.
    always_comb begin
        if (w_k_bad) begin
            w_code = 3'd1;
        end else if (w_w_big) begin
            w_code = 3'd2;
        end else if (w_fit_bad) begin
            w_code = 3'd3;
        end else if (w_ch_bad) begin
            w_code = 3'd4;
        end else begin
            w_code = 3'd0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        act_layer_d = act_layer_q;
        act_img_w_d = act_img_w_q;
        act_img_h_d = act_img_h_q;
        act_k_r_d   = act_k_r_q;
        act_k_s_d   = act_k_s_q;
        act_k_ch_d  = act_k_ch_q;
        act_mode_d  = act_mode_q;
        act_out_w_d = act_out_w_q;
        act_out_h_d = act_out_h_q;
        act_ifm_d   = act_ifm_q;
        act_ofm_d   = act_ofm_q;
        case (state_q)
            S_IDLE: begin
                if (run_start) begin
                    state_d    = S_CHECK;
                    idx_d      = '0;
                    last_d     = w_run_last;
                    err_d      = 1'b0;
                    err_code_d = 3'd0;
                end
            end
            S_CHECK: begin
                // The active registers are a snapshot; later table writes
                // cannot reach the datapath until the next CHECK.
                act_layer_d = idx_q;
                act_img_w_d = w_cur_img_w;
                act_img_h_d = w_cur_img_h;
                act_k_r_d   = w_cur_k_r;
                act_k_s_d   = w_cur_k_s;
                act_k_ch_d  = w_cur_k_ch;
                act_mode_d  = tab_mode_q[idx_q];
                act_ifm_d   = tab_ifm_q[idx_q];
                act_ofm_d   = tab_ofm_q[idx_q];
                act_out_w_d = w_cur_img_w - DIM_W'(w_cur_k_s) + DIM_W'(1);
                act_out_h_d = w_cur_img_h - DIM_W'(w_cur_k_r) + DIM_W'(1);
                if (w_code != 3'd0) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = w_code;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (layer_ready) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (layer_done) begin
                    if (idx_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + LIDX_W'(1);
                        state_d = S_CHECK;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                tab_img_w_q[i] <= DIM_W'(28);
                tab_img_h_q[i] <= DIM_W'(28);
                tab_k_r_q[i]   <= 3'd5;
                tab_k_s_q[i]   <= 3'd5;
                tab_k_ch_q[i]  <= 5'd6;
                tab_mode_q[i]  <= 1'b0;
                tab_ifm_q[i]   <= '0;
                tab_ofm_q[i]   <= '0;
            end
            state_q      <= S_IDLE;
            idx_q        <= '0;
            last_q       <= '0;
            err_q        <= 1'b0;
            err_code_q   <= 3'd0;
            cfg_wr_err_q <= 1'b0;
            act_layer_q  <= '0;
            act_img_w_q  <= '0;
            act_img_h_q  <= '0;
            act_k_r_q    <= 3'd0;
            act_k_s_q    <= 3'd0;
            act_k_ch_q   <= 5'd0;
            act_mode_q   <= 1'b0;
            act_out_w_q  <= '0;
            act_out_h_q  <= '0;
            act_ifm_q    <= '0;
            act_ofm_q    <= '0;
        end else begin
            tab_img_w_q  <= tab_img_w_d;
            tab_img_h_q  <= tab_img_h_d;
            tab_k_r_q    <= tab_k_r_d;
            tab_k_s_q    <= tab_k_s_d;
            tab_k_ch_q   <= tab_k_ch_d;
            tab_mode_q   <= tab_mode_d;
            tab_ifm_q    <= tab_ifm_d;
            tab_ofm_q    <= tab_ofm_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            cfg_wr_err_q <= cfg_wr_err_d;
            act_layer_q  <= act_layer_d;
            act_img_w_q  <= act_img_w_d;
            act_img_h_q  <= act_img_h_d;
            act_k_r_q    <= act_k_r_d;
            act_k_s_q    <= act_k_s_d;
            act_k_ch_q   <= act_k_ch_d;
            act_mode_q   <= act_mode_d;
            act_out_w_q  <= act_out_w_d;
            act_out_h_q  <= act_out_h_d;
            act_ifm_q    <= act_ifm_d;
            act_ofm_q    <= act_ofm_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_wr_err  = cfg_wr_err_q;
    assign layer_valid = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign run_done    = (state_q == S_DONE);
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign act_layer   = act_layer_q;
    assign act_img_w   = act_img_w_q;
    assign act_img_h   = act_img_h_q;
    assign act_k_r     = act_k_r_q;
    assign act_k_s     = act_k_s_q;
    assign act_k_ch    = act_k_ch_q;
    assign act_mode    = act_mode_q;
    assign act_out_w   = act_out_w_q;
    assign act_out_h   = act_out_h_q;
    assign act_ifm     = act_ifm_q;
    assign act_ofm     = act_ofm_q;

`ifdef CFG_READBACK_EN
    // Readback samples the table before any same-cycle write lands, so a
    // simultaneous read and write of one address returns the old value.
    logic [31:0] rd_data_q, rd_data_d, w_rd_word;

    always_comb begin
        w_rd_word = '0;
        if (w_layer_ok) begin
            case (w_addr_field)
                F_IMG_W:    w_rd_word = 32'(tab_img_w_q[w_addr_layer]);
                F_IMG_H:    w_rd_word = 32'(tab_img_h_q[w_addr_layer]);
                F_K_R:      w_rd_word = 32'(tab_k_r_q[w_addr_layer]);
                F_K_S:      w_rd_word = 32'(tab_k_s_q[w_addr_layer]);
                F_K_CH:     w_rd_word = 32'(tab_k_ch_q[w_addr_layer]);
                F_MODE:     w_rd_word = 32'(tab_mode_q[w_addr_layer]);
                F_IFM_BASE: w_rd_word = 32'(tab_ifm_q[w_addr_layer]);
                default:    w_rd_word = 32'(tab_ofm_q[w_addr_layer]);
            endcase
        end
        rd_data_d = cfg_rd_en ? w_rd_word : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign cfg_rd_data = rd_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_cfg_sequencer
// Description : Self-checking bench for layer_cfg_sequencer. Uses a vector
//               table of hand-computed layer configs, a few directed
//               scenarios, and randomized table writes and runs checked
//               against a behavioural model of the config table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_cfg_sequencer;

    localparam int NL = 4;
    localparam int LW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [31:0] cfg_wr_data = '0;
    logic        cfg_wr_err;
    logic        run_start = 1'b0;
    logic [1:0]  run_last = '0;
    logic        layer_valid;
    logic        layer_ready = 1'b0;
    logic        layer_done = 1'b0;
    logic [1:0]  act_layer;
    logic [10:0] act_img_w, act_img_h, act_out_w, act_out_h;
    logic [2:0]  act_k_r, act_k_s;
    logic [4:0]  act_k_ch;
    logic        act_mode;
    logic [11:0] act_ifm, act_ofm;
    logic        busy, run_done, err;
    logic [2:0]  err_code;
`ifdef CFG_READBACK_EN
    logic        cfg_rd_en = 1'b0;
    logic [31:0] cfg_rd_data;
`endif

    always #5 clk = ~clk;

    layer_cfg_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_wr_err(cfg_wr_err),
        .run_start(run_start), .run_last(run_last),
        .layer_valid(layer_valid), .layer_ready(layer_ready), .layer_done(layer_done),
        .act_layer(act_layer), .act_img_w(act_img_w), .act_img_h(act_img_h),
        .act_k_r(act_k_r), .act_k_s(act_k_s), .act_k_ch(act_k_ch), .act_mode(act_mode),
        .act_out_w(act_out_w), .act_out_h(act_out_h), .act_ifm(act_ifm), .act_ofm(act_ofm),
        .busy(busy), .run_done(run_done), .err(err), .err_code(err_code)
`ifdef CFG_READBACK_EN
        , .cfg_rd_en(cfg_rd_en), .cfg_rd_data(cfg_rd_data)
`endif
    );

    typedef struct packed {
        int img_w; int img_h; int k_r; int k_s; int k_ch; int mode; int ifm; int ofm;
    } cfg_t;

    typedef struct packed {
        cfg_t cfg; int code; int out_w; int out_h;
    } vec_t;

    cfg_t mtab [NL];
    vec_t vecs [12];
    int   checks = 0;
    int   failures = 0;
    int   obs_code, obs_out_w, obs_out_h;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic cfg_t mk_cfg(int w, int h, int kr, int ks, int ch, int md, int fi, int fo);
        cfg_t c;
        c.img_w = w; c.img_h = h; c.k_r = kr; c.k_s = ks;
        c.k_ch = ch; c.mode = md; c.ifm = fi; c.ofm = fo;
        return c;
    endfunction

    function automatic vec_t mk_vec(cfg_t c, int code, int ow, int oh);
        vec_t v;
        v.cfg = c; v.code = code; v.out_w = ow; v.out_h = oh;
        return v;
    endfunction

    function automatic int field_bits(int f);
        case (f)
            0, 1:    return 11;
            2, 3:    return 3;
            4:       return 5;
            5:       return 1;
            default: return 12;
        endcase
    endfunction

    function automatic int get_field(cfg_t c, int f);
        case (f)
            0: return c.img_w;  1: return c.img_h;
            2: return c.k_r;    3: return c.k_s;
            4: return c.k_ch;   5: return c.mode;
            6: return c.ifm;    default: return c.ofm;
        endcase
    endfunction

    task automatic set_field(int l, int f, int v);
        case (f)
            0: mtab[l].img_w = v;  1: mtab[l].img_h = v;
            2: mtab[l].k_r = v;    3: mtab[l].k_s = v;
            4: mtab[l].k_ch = v;   5: mtab[l].mode = v;
            6: mtab[l].ifm = v;    default: mtab[l].ofm = v;
        endcase
    endtask

    function automatic int exp_code(cfg_t c);
        if (c.k_r == 0 || c.k_s == 0 || c.k_r > 7 || c.k_s > 7) return 1;
        if (c.img_w > 1920) return 2;
        if (c.k_s > c.img_w || c.k_r > c.img_h) return 3;
        if (c.k_ch == 0 || c.k_ch > 16) return 4;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) mtab[i] = mk_cfg(28, 28, 5, 5, 6, 0, 0, 0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cfg_write(input int l, input int f, input int v, input bit busy_now);
        bit exp_err;
        cfg_wr_en = 1'b1;
        cfg_addr = 5'((l << 3) | f);
        cfg_wr_data = 32'(v);
        tick();
        cfg_wr_en = 1'b0;
        exp_err = busy_now || ((v >> field_bits(f)) != 0);
        check("cfg_wr_err", cfg_wr_err, exp_err);
        if (!exp_err) set_field(l, f, v);
    endtask

    task automatic write_layer(input int l, input cfg_t c);
        for (int f = 0; f < 8; f++) cfg_write(l, f, get_field(c, f), 1'b0);
    endtask

    function automatic int rand_val(int f);
        case (f)
            0, 1:    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(1900, 2100))
                                                       : int'($urandom_range(1, 40));
            2, 3:    return $urandom_range(0, 8);
            4:       return $urandom_range(0, 33);
            5:       return $urandom_range(0, 2);
            default: return $urandom_range(0, 4200);
        endcase
    endfunction

    task automatic check_act(input int idx);
        cfg_t c;
        c = mtab[idx];
        check("act_layer", act_layer, idx);
        check("act_img_w", act_img_w, c.img_w);
        check("act_img_h", act_img_h, c.img_h);
        check("act_k_r", act_k_r, c.k_r);
        check("act_k_s", act_k_s, c.k_s);
        check("act_k_ch", act_k_ch, c.k_ch);
        check("act_mode", act_mode, c.mode);
        check("act_out_w", act_out_w, c.img_w - c.k_s + 1);
        check("act_out_h", act_out_h, c.img_h - c.k_r + 1);
        check("act_ifm", act_ifm, c.ifm);
        check("act_ofm", act_ofm, c.ofm);
    endtask

    // Runs layers 0..last with fixed-latency expectations. hold = cycles
    // with layer_ready low; poke = pulse done/run_start during ISSUE;
    // wr_busy = attempt a table write while the layer is BUSY.
    task automatic run_layers(input int last, input int hold, input bit poke, input bit wr_busy);
        cfg_t c;
        int   code;
        run_last = 2'(last);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        for (int idx = 0; idx <= last; idx++) begin
            c = mtab[idx];
            code = exp_code(c);
            check("valid_in_check", layer_valid, 0);
            check("busy_in_check", busy, 1);
            tick();
            if (code != 0) begin
                obs_code = err_code; obs_out_w = -1; obs_out_h = -1;
                check("err_flag", err, 1);
                check("err_code", err_code, code);
                check("valid_on_err", layer_valid, 0);
                tick();
                check("busy_after_err", busy, 0);
                check("err_sticky", err, 1);
                check("run_done_on_err", run_done, 0);
                return;
            end
            obs_code = err_code; obs_out_w = act_out_w; obs_out_h = act_out_h;
            check("layer_valid", layer_valid, 1);
            check("err_clear", err, 0);
            check_act(idx);
            for (int h = 0; h < hold; h++) begin
                if (poke && h == 0) begin
                    layer_done = 1'b1;
                    run_start = 1'b1;
                end
                tick();
                layer_done = 1'b0;
                run_start = 1'b0;
                check("valid_hold", layer_valid, 1);
                check("out_w_hold", act_out_w, c.img_w - c.k_s + 1);
                check("layer_hold", act_layer, idx);
            end
            layer_ready = 1'b1;
            tick();
            layer_ready = 1'b0;
            check("valid_after_hs", layer_valid, 0);
            check("busy_in_busy", busy, 1);
            if (wr_busy) begin
                cfg_write(int'($urandom_range(0, NL - 1)), 0, 9, 1'b1);
                check("act_after_busy_wr", act_img_w, c.img_w);
            end
            layer_done = 1'b1;
            tick();
            layer_done = 1'b0;
            if (idx == last) begin
                check("run_done", run_done, 1);
                tick();
                check("run_done_pulse", run_done, 0);
                check("busy_idle", busy, 0);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = mk_vec(mk_cfg(28, 28, 5, 5, 6, 0, 0, 0),            0, 24, 24);
        vecs[1]  = mk_vec(mk_cfg(12, 20, 3, 3, 8, 1, 256, 512),        0, 10, 18);
        vecs[2]  = mk_vec(mk_cfg(1920, 1080, 7, 7, 16, 0, 4095, 1),    0, 1914, 1074);
        vecs[3]  = mk_vec(mk_cfg(1921, 10, 3, 3, 4, 0, 0, 0),          2, 0, 0);
        vecs[4]  = mk_vec(mk_cfg(8, 8, 0, 3, 4, 0, 0, 0),              1, 0, 0);
        vecs[5]  = mk_vec(mk_cfg(2, 8, 3, 3, 4, 0, 0, 0),              3, 0, 0);
        vecs[6]  = mk_vec(mk_cfg(8, 8, 3, 3, 0, 0, 0, 0),              4, 0, 0);
        vecs[7]  = mk_vec(mk_cfg(8, 8, 3, 3, 17, 0, 0, 0),             4, 0, 0);
        vecs[8]  = mk_vec(mk_cfg(2000, 10, 0, 3, 0, 0, 0, 0),          1, 0, 0);
        vecs[9]  = mk_vec(mk_cfg(3, 3, 3, 3, 1, 1, 7, 9),              0, 1, 1);
        vecs[10] = mk_vec(mk_cfg(8, 2, 3, 1, 1, 0, 0, 0),              3, 0, 0);
        vecs[11] = mk_vec(mk_cfg(1921, 5, 7, 7, 16, 0, 0, 0),          2, 0, 0);

        model_reset();
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        check("rst_busy", busy, 0);
        check("rst_valid", layer_valid, 0);
        check("rst_run_done", run_done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_wr_err", cfg_wr_err, 0);
        check("rst_act_img_w", act_img_w, 0);
        check("rst_act_out_w", act_out_w, 0);
        check("rst_act_k_ch", act_k_ch, 0);

        // Default table, single layer
        run_layers(0, 0, 1'b0, 1'b0);
        check("default_out_w", obs_out_w, 24);
        check("default_out_h", obs_out_h, 24);

        // Table-driven single-layer vectors
        for (int v = 0; v < 12; v++) begin
            write_layer(0, vecs[v].cfg);
            run_layers(0, v % 3, 1'(v % 2), 1'(v == 1));
            check("vec_code", obs_code, vecs[v].code);
            if (vecs[v].code == 0) begin
                check("vec_out_w", obs_out_w, vecs[v].out_w);
                check("vec_out_h", obs_out_h, vecs[v].out_h);
            end
        end

        // Two layers, second with a 3x3 kernel
        write_layer(0, mk_cfg(28, 28, 5, 5, 6, 0, 0, 0));
        write_layer(1, mk_cfg(12, 12, 3, 3, 4, 1, 100, 200));
        run_layers(1, 1, 1'b0, 1'b0);
        check("two_layer_out_w", obs_out_w, 10);

        // Layer 0 ok, layer 1 too wide
        cfg_write(0, 2, 6, 1'b0);
        cfg_write(1, 0, 2000, 1'b0);
        run_layers(1, 0, 1'b0, 1'b0);
        check("second_layer_code", obs_code, 2);

        // Oversize field write rejected in IDLE
        cfg_write(2, 2, 8, 1'b0);
        cfg_write(2, 4, 32, 1'b0);

        // Long ready stall with ignored done/run_start and a write in BUSY
        write_layer(0, mk_cfg(64, 48, 3, 5, 16, 1, 33, 44));
        run_layers(0, 10, 1'b1, 1'b1);

        // Randomized writes and runs
        for (int it = 0; it < 30; it++) begin
            for (int n = 0; n < int'($urandom_range(0, 6)); n++) begin
                int l, f;
                l = $urandom_range(0, NL - 1);
                f = $urandom_range(0, 7);
                cfg_write(l, f, rand_val(f), 1'b0);
            end
            run_layers(int'($urandom_range(0, NL - 1)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef CFG_READBACK_EN
        begin
            int old_v;
            old_v = mtab[2].img_w;
            cfg_rd_en = 1'b1;
            cfg_wr_en = 1'b1;
            cfg_addr = 5'((2 << 3) | 0);
            cfg_wr_data = 32'd40;
            tick();
            cfg_rd_en = 1'b0;
            cfg_wr_en = 1'b0;
            check("rd_old_value", cfg_rd_data, old_v);
            mtab[2].img_w = 40;
            cfg_rd_en = 1'b1;
            tick();
            cfg_rd_en = 1'b0;
            check("rd_new_value", cfg_rd_data, 40);
        end
`endif

        // Asynchronous reset in the middle of a BUSY layer
        write_layer(0, mk_cfg(30, 30, 3, 3, 5, 1, 10, 20));
        run_last = 2'd0;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        tick();
        layer_ready = 1'b1;
        tick();
        layer_ready = 1'b0;
        check("busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", layer_valid, 0);
        check("mid_rst_act_img_w", act_img_w, 0);
        check("mid_rst_act_out_w", act_out_w, 0);
        check("mid_rst_act_mode", act_mode, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        tick();
`ifdef CFG_READBACK_EN
        cfg_rd_en = 1'b1;
        cfg_addr = 5'd0;
        tick();
        cfg_rd_en = 1'b0;
        check("rd_after_rst", cfg_rd_data, 28);
`endif
        run_layers(0, 0, 1'b0, 1'b0);
        check("post_rst_out_w", obs_out_w, 24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
